alu_op_dispatch: RTL and testbench
==================================

Name: alu_op_dispatch

Overview:
- Issue side of the ALU result-select path: accepts one operation request (opcode + operands) and decodes the opcode into a one-hot start pulse to one of four functional units (add, sub, and, or).
- Waits for the selected unit's done, captures its result, and returns it on a response handshake.
- Invalid opcodes and unresponsive units are reported as errors.
- Sits between the instruction/control logic and the four ALU units.

Parameters:
- WIDTH, 8, operand and result width in bits.
- TIMEOUT, 15, maximum cycles spent in WAIT before an error response; legal range 2..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  dispatcher can accept a request.
- req_opcode  input  3  000 add, 001 sub, 010 and, 011 or, 1xx invalid.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- unit_start  output  4  one-hot start; bit0 add, bit1 sub, bit2 and, bit3 or.
- unit_a  output  WIDTH  registered operand A to units.
- unit_b  output  WIDTH  registered operand B to units.
- unit_done  input  4  per-unit done, same bit mapping as unit_start.
- unit_result  input  WIDTH  shared result bus, valid when the selected done bit is high.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  captured result; 0 on error.
- rsp_err  output  1  invalid opcode or timeout.
- rsp_opcode  output  3  opcode of the request being answered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - unit_start, unit_a, unit_b, rsp_valid, rsp_data, rsp_err, rsp_opcode and the timeout counter clear to 0.
  - req_ready is decoded from state, so it reads 1 immediately.
  - Reset mid-operation abandons the request with no response; a late unit_done after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1. On req_valid&&req_ready, register opcode, a and b.
  - Opcode 1xx: go to RESP with rsp_err=1, rsp_data=0. No unit_start is issued.
  - Opcode 0xx: go to ISSUE.
- ISSUE (exactly one cycle):
  - unit_start = one-hot of opcode[1:0]; all other bits 0.
  - unit_a and unit_b hold the captured operands and stay stable until the next accept.
  - unit_done is ignored in this cycle. Go to WAIT; counter=0.
- WAIT:
  - Only unit_done[opcode[1:0]] is observed; done bits of other units are ignored.
  - On selected done: rsp_data<=unit_result, rsp_err<=0, go to RESP.
  - No done: counter increments. If counter==TIMEOUT-1 in a cycle without done, rsp_err<=1, rsp_data<=0, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1. rsp_data, rsp_err and rsp_opcode are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- req_ready=0 in ISSUE, WAIT and RESP; at most one request is in flight.
- Minimum latency, accept edge to rsp_valid high: valid opcode with done in the first WAIT cycle = 3 cycles; invalid opcode = 1 cycle.
- Back-to-back: after the RESP handshake, the next request can be accepted in the following cycle (IDLE).
- unit_start is never asserted outside ISSUE and is never multi-hot.

Test Plan:
- Reset, then request op=000, a=8'h05, b=8'h03 -> unit_start=4'b0001 for one cycle, unit_a=05, unit_b=03; unit responds done[0] with result 8'h08 one cycle later -> rsp_valid, rsp_data=08, rsp_err=0, rsp_opcode=000.
- Request op=011, a=F0, b=0F; assert unit_done=4'b0001 (wrong unit) for 2 cycles, then 4'b1000 with result FF -> wrong done ignored, rsp_data=FF, rsp_err=0.
- Request op=101 -> no unit_start, rsp_valid one cycle after accept, rsp_err=1, rsp_data=0; hold rsp_ready=0 for 4 cycles -> outputs stable and req_ready=0 throughout.
- Request op=001, never assert done, TIMEOUT=15 -> rsp_err=1, rsp_data=0, rsp_valid rises 15 cycles after the WAIT entry edge; then assert done[1] in the final WAIT cycle on a second run -> result returned, rsp_err=0.
- Request op=010, pull rst_n low during WAIT -> outputs cleared immediately; late done[2] after release -> ignored; new request op=000 completes normally.

Source files
------------

// File: rtl/alu_op_dispatch.sv
// Issue side of the ALU result-select path: decodes one request into a one-hot
// unit start, waits for that unit's done (bounded by TIMEOUT), and returns the result.
//
// state | meaning
// IDLE  | ready for a request; operands and opcode captured on accept
// ISSUE | one-cycle start pulse to the selected unit
// WAIT  | watching the selected unit's done, counting toward TIMEOUT
// RESP  | response presented until rsp_ready
module alu_op_dispatch #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       unit_start,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic [3:0]       unit_done,
    input  logic [WIDTH-1:0] unit_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [2:0]       rsp_opcode
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             sel_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Only the done bit of the unit we started counts.
    assign sel_done = unit_done[opcode_q[1:0]];

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    opcode_d = req_opcode;
                    a_d      = req_a;
                    b_d      = req_b;
                    if (req_opcode[2]) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (sel_done) begin
                    rsp_data_d = unit_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unit_start = '0;
        if (state_q == ISSUE) unit_start[opcode_q[1:0]] = 1'b1;
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_opcode = opcode_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Directed bench for alu_op_dispatch: stimulus pushes expected responses into a
// queue, a monitor pops and compares on every response handshake.
module tb_alu_op_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [2:0] req_opcode;
    logic [7:0] req_a, req_b;
    logic [3:0] unit_start, unit_done;
    logic [7:0] unit_a, unit_b, unit_result;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_data;
    logic [2:0] rsp_opcode;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] op;
        logic       err;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    alu_op_dispatch #(.WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_opcode(rsp_opcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a request just after an edge; returns just after the accept edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        @(negedge clk);
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Monitor: compare every handshaked response against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("unit_start_onehot0", 32'($onehot0(unit_start)), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_opcode", 32'(rsp_opcode), 32'(e.op));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
        unit_done = '0; unit_result = '0; rsp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_unit_start", 32'(unit_start), 32'd0);
        chk("rst_unit_a", 32'(unit_a), 32'd0);
        chk("rst_rsp_data_err_op", 32'({rsp_data, rsp_err, rsp_opcode}), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // add: done one cycle after start
        exp_q.push_back('{3'b000, 1'b0, 8'h08});
        send(3'b000, 8'h05, 8'h03);
        @(negedge clk);
        chk("t1_unit_start", 32'(unit_start), 32'b0001);
        chk("t1_unit_a", 32'(unit_a), 32'h05);
        chk("t1_unit_b", 32'(unit_b), 32'h03);
        chk("t1_req_ready_issue", 32'(req_ready), 32'd0);
        step();
        unit_done = 4'b0001; unit_result = 8'h08;
        @(negedge clk);
        chk("t1_unit_start_wait", 32'(unit_start), 32'd0);
        step();
        unit_done = '0;
        @(negedge clk);
        chk("t1_rsp_valid_latency", 32'(rsp_valid), 32'd1);
        step();
        @(negedge clk);
        chk("t1_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("t1_back_to_idle", 32'(req_ready), 32'd1);
        step();

        // or: wrong unit's done must be ignored
        exp_q.push_back('{3'b011, 1'b0, 8'hFF});
        send(3'b011, 8'hF0, 8'h0F);
        @(negedge clk);
        chk("t2_unit_start", 32'(unit_start), 32'b1000);
        step();
        unit_done = 4'b0001; unit_result = 8'hAA;
        step();
        step();
        @(negedge clk);
        chk("t2_wrong_done_ignored", 32'(rsp_valid), 32'd0);
        unit_done = 4'b1000; unit_result = 8'hFF;
        step();
        unit_done = '0;
        @(negedge clk);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        step(); step();

        // invalid opcode with a stalled consumer
        rsp_ready = 1'b0;
        exp_q.push_back('{3'b101, 1'b1, 8'h00});
        send(3'b101, 8'h11, 8'h22);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_no_start", 32'(unit_start), 32'd0);
            chk("t3_rsp_valid_held", 32'(rsp_valid), 32'd1);
            chk("t3_req_ready_low", 32'(req_ready), 32'd0);
            chk("t3_held_fields", 32'({rsp_opcode, rsp_err, rsp_data}), 32'({3'b101, 1'b1, 8'h00}));
            step();
        end
        rsp_ready = 1'b1;
        step(); step();

        // sub: timeout after 15 WAIT cycles
        exp_q.push_back('{3'b001, 1'b1, 8'h00});
        send(3'b001, 8'h12, 8'h34);
        step();
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk("t4_timeout_cycles", 32'(n), 32'd15);
        step(); step();

        // sub: done arrives in the final WAIT cycle and wins over the timeout
        exp_q.push_back('{3'b001, 1'b0, 8'h5A});
        send(3'b001, 8'h60, 8'h06);
        step();
        for (int i = 0; i < 14; i++) step();
        chk("t4_still_waiting", 32'(rsp_valid), 32'd0);
        unit_done = 4'b0010; unit_result = 8'h5A;
        step();
        unit_done = '0;
        chk("t4_done_wins", 32'(rsp_valid), 32'd1);
        step(); step();

        // and: reset while in WAIT, late done ignored
        send(3'b010, 8'h33, 8'h44);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_unit_a", 32'(unit_a), 32'd0);
        chk("t5_rst_unit_b", 32'(unit_b), 32'd0);
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_req_ready", 32'(req_ready), 32'd1);
        chk("t5_rst_rsp_opcode", 32'(rsp_opcode), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        unit_done = 4'b0100; unit_result = 8'h77;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_late_done_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("t5_late_done_req_ready", 32'(req_ready), 32'd1);
            step();
        end
        unit_done = '0;
        exp_q.push_back('{3'b000, 1'b0, 8'h03});
        send(3'b000, 8'h01, 8'h02);
        step();
        unit_done = 4'b0001; unit_result = 8'h03;
        step();
        unit_done = '0;
        chk("t5_recovery_rsp_valid", 32'(rsp_valid), 32'd1);
        step(); step(); step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
